// File: rtl/pong_merge.sv
// Converging end of a ping-pong lane pair: merges two alternating lanes into one 2-deep FIFO.
// Optional delivered-item counter port merge_count is built when PONG_MERGE_COUNT_EN is defined.
module pong_merge #(
    parameter int width = 704
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in0_enq__ENA,
    input  logic [width-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [width-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    output logic [width-1:0] out_first,
    output logic             out_first__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY
`ifdef PONG_MERGE_COUNT_EN
    ,
    output logic [15:0]      merge_count
`endif
);

    logic             sel;
    logic             wptr;
    logic             rptr;
    logic [1:0]       count;
    logic [width-1:0] mem [2];

    logic             not_full;
    logic             has_item;
    logic             fire0;
    logic             fire1;
    logic             enq_fire;
    logic             deq_fire;
    logic [width-1:0] enq_data;
    logic [1:0]       count_nxt;

    assign not_full = (count != 2'd2);
    assign has_item = (count != 2'd0);

    // Only the lane whose turn it is may ever see RDY.
    assign in0_enq__RDY = ~sel & not_full;
    assign in1_enq__RDY = sel & not_full;

    assign fire0    = in0_enq__ENA & in0_enq__RDY;
    assign fire1    = in1_enq__ENA & in1_enq__RDY;
    assign enq_fire = fire0 | fire1;

    assign out_first__RDY = has_item;
    assign out_deq__RDY   = has_item;
    assign deq_fire       = out_deq__ENA & has_item;

    assign out_first = has_item ? mem[rptr] : '0;

    always_comb begin
        enq_data = in0_enq_v;
        unique case (1'b1)
            fire1:   enq_data = in1_enq_v;
            default: enq_data = in0_enq_v;
        endcase
    end

    always_comb begin
        count_nxt = count;
        unique case ({enq_fire, deq_fire})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sel   <= 1'b0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            count <= count_nxt;
            if (enq_fire) begin
                sel  <= ~sel;
                wptr <= ~wptr;
            end
            if (deq_fire) begin
                rptr <= ~rptr;
            end
        end
    end

    // Storage needs no reset; count gates visibility of stale entries.
    always_ff @(posedge CLK) begin
        if (nRST && enq_fire) begin
            mem[wptr] <= enq_data;
        end
    end

`ifdef PONG_MERGE_COUNT_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            merge_count <= 16'd0;
        end else if (deq_fire) begin
            merge_count <= merge_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pong_merge.sv
// Self-checking bench for pong_merge (width=32): directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pong_merge;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         in0_ena = 1'b0;
    logic [W-1:0] in0_v = '0;
    logic         in0_rdy;
    logic         in1_ena = 1'b0;
    logic [W-1:0] in1_v = '0;
    logic         in1_rdy;
    logic [W-1:0] first;
    logic         first_rdy;
    logic         deq_ena = 1'b0;
    logic         deq_rdy;
`ifdef PONG_MERGE_COUNT_EN
    logic [15:0]  mcount;
`endif

    int checks = 0;
    int errors = 0;

    pong_merge #(.width(W)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .in0_enq__ENA   (in0_ena),
        .in0_enq_v      (in0_v),
        .in0_enq__RDY   (in0_rdy),
        .in1_enq__ENA   (in1_ena),
        .in1_enq_v      (in1_v),
        .in1_enq__RDY   (in1_rdy),
        .out_first      (first),
        .out_first__RDY (first_rdy),
        .out_deq__ENA   (deq_ena),
        .out_deq__RDY   (deq_rdy)
`ifdef PONG_MERGE_COUNT_EN
        ,
        .merge_count    (mcount)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: items accepted in order, lane turn = parity of accepted count.
    logic [W-1:0] mq[$];
    int unsigned  m_acc = 0;
    int unsigned  m_del = 0;

    always @(posedge CLK) begin
        automatic logic f0, f1, fd;
        automatic logic [W-1:0] junk;
        if (!nRST) begin
            mq.delete();
            m_acc <= 0;
            m_del <= 0;
        end else begin
            f0 = in0_ena && (m_acc % 2 == 0) && (mq.size() < 2);
            f1 = in1_ena && (m_acc % 2 == 1) && (mq.size() < 2);
            fd = deq_ena && (mq.size() != 0);
            if (fd) begin
                junk = mq.pop_front();
                m_del <= m_del + 1;
            end
            if (f0) mq.push_back(in0_v);
            else if (f1) mq.push_back(in1_v);
            if (f0 || f1) m_acc <= m_acc + 1;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        in0_ena = 1'b0;
        in1_ena = 1'b0;
        deq_ena = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        cyc();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in0_rdy, in1_rdy, first_rdy, deq_rdy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_rdy: got %b expected 1000",
                     {in0_rdy, in1_rdy, first_rdy, deq_rdy});
        end
        checks++;
        if (first !== '0) begin
            errors++;
            $display("FAIL reset_first: got %h expected 0", first);
        end
    endtask

    task automatic test_fill_order();
        do_reset();
        in0_ena = 1'b1; in0_v = 32'hA0;
        cyc();
        idle();
        checks++;
        if ({in0_rdy, in1_rdy} !== 2'b01 || first !== 32'hA0) begin
            errors++;
            $display("FAIL fill_first: rdy %b first %h expected 01 a0",
                     {in0_rdy, in1_rdy}, first);
        end
        in1_ena = 1'b1; in1_v = 32'hB1;
        cyc();
        idle();
        checks++;
        if ({in0_rdy, in1_rdy, first_rdy} !== 3'b001) begin
            errors++;
            $display("FAIL fill_full: got %b expected 001",
                     {in0_rdy, in1_rdy, first_rdy});
        end
        in0_ena = 1'b1; in0_v = 32'hA2;
        cyc();
        idle();
        deq_ena = 1'b1;
        cyc();
        checks++;
        if (first !== 32'hB1 || first_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fill_deq1: got %h/%b expected b1/1", first, first_rdy);
        end
        cyc();
        idle();
        checks++;
        if (first_rdy !== 1'b0 || first !== '0) begin
            errors++;
            $display("FAIL fill_deq2: got %b/%h expected 0/0 (A2 must be dropped)",
                     first_rdy, first);
        end
    endtask

    task automatic test_wrong_lane();
        do_reset();
        in1_ena = 1'b1; in1_v = 32'h55;
        cyc();
        idle();
        checks++;
        if ({in0_rdy, in1_rdy, first_rdy} !== 3'b100) begin
            errors++;
            $display("FAIL wrong_lane: got %b expected 100",
                     {in0_rdy, in1_rdy, first_rdy});
        end
    endtask

    task automatic test_stream();
        int exp_next = 0;
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            idle();
            if (i < 10) begin
                if (i % 2 == 0) begin in0_ena = 1'b1; in0_v = i; end
                else begin in1_ena = 1'b1; in1_v = i; end
                checks++;
                if ((i % 2 == 0 ? in0_rdy : in1_rdy) !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_rdy: item %0d lane rdy 0 expected 1", i);
                end
            end
            if (first_rdy) begin
                deq_ena = 1'b1;
                checks++;
                if (first !== exp_next) begin
                    errors++;
                    $display("FAIL stream_order: got %h expected %h", first, exp_next);
                end
                exp_next++;
            end
            cyc();
        end
        idle();
        checks++;
        if (exp_next != 10 || first_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: delivered %0d rdy %b expected 10 0",
                     exp_next, first_rdy);
        end
    endtask

    task automatic test_full_deq();
        do_reset();
        in0_ena = 1'b1; in0_v = 32'h11;
        cyc();
        idle();
        in1_ena = 1'b1; in1_v = 32'h22;
        cyc();
        idle();
        deq_ena = 1'b1;
        #1;
        checks++;
        if (in0_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_same_cycle: in0_rdy %b expected 0", in0_rdy);
        end
        cyc();
        idle();
        checks++;
        if (in0_rdy !== 1'b1 || first !== 32'h22) begin
            errors++;
            $display("FAIL full_reopen: rdy %b first %h expected 1 22", in0_rdy, first);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in0_ena = 1'b1; in0_v = 32'hCC;
        cyc();
        idle();
        deq_ena = 1'b1;
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        idle();
        checks++;
        if ({in0_rdy, in1_rdy, first_rdy} !== 3'b100 || first !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy %b first %h expected 100 0",
                     {in0_rdy, in1_rdy, first_rdy}, first);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ef;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in0_ena = 1'($urandom_range(0, 1));
            in1_ena = 1'($urandom_range(0, 1));
            deq_ena = ($urandom_range(0, 2) != 0);
            in0_v   = $urandom;
            in1_v   = $urandom;
            #1;
            ef = (mq.size() != 0) ? mq[0] : '0;
            checks++;
            if (first !== ef || first_rdy !== (mq.size() != 0) ||
                deq_rdy !== (mq.size() != 0) ||
                in0_rdy !== (m_acc % 2 == 0 && mq.size() < 2) ||
                in1_rdy !== (m_acc % 2 == 1 && mq.size() < 2)) begin
                errors++;
                $display("FAIL random[%0d]: first %h rdy %b%b%b%b expected %h size %0d acc %0d",
                         i, first, in0_rdy, in1_rdy, first_rdy, deq_rdy,
                         ef, mq.size(), m_acc);
            end
`ifdef PONG_MERGE_COUNT_EN
            checks++;
            if (mcount !== 16'(m_del)) begin
                errors++;
                $display("FAIL random_count: got %h expected %h", mcount, 16'(m_del));
            end
`endif
            cyc();
        end
        idle();
    endtask

`ifdef PONG_MERGE_COUNT_EN
    task automatic test_counter();
        do_reset();
        in0_ena = 1'b1; in0_v = 0;
        cyc();
        for (int i = 1; i <= 65534; i++) begin
            idle();
            if (i % 2 == 0) begin in0_ena = 1'b1; in0_v = i; end
            else begin in1_ena = 1'b1; in1_v = i; end
            deq_ena = 1'b1;
            cyc();
        end
        idle();
        checks++;
        if (mcount !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_fffe: got %h expected fffe", mcount);
        end
        in1_ena = 1'b1; in1_v = 32'h1;
        deq_ena = 1'b1;
        cyc();
        idle();
        deq_ena = 1'b1;
        cyc();
        idle();
        checks++;
        if (mcount !== 16'h0000 || first_rdy !== 1'b0) begin
            errors++;
            $display("FAIL count_wrap: got %h/%b expected 0000/0", mcount, first_rdy);
        end
    endtask
`endif

    initial begin
        @(negedge CLK);
        test_reset();
        test_fill_order();
        test_wrong_lane();
        test_stream();
        test_full_deq();
        test_reset_mid();
        test_random();
`ifdef PONG_MERGE_COUNT_EN
        test_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
